exc_seq: RTL and testbench

EXC_SEQ -- requirements
Module: exc_seq

---
 rtl/exc_seq_pkg.sv | 41 ++++
 rtl/exc_wait_cnt.sv | 41 ++++
 rtl/exc_seq.sv | 135 +++++++++++++
 tb/tb_exc_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/exc_seq_pkg.sv
// Shared constants for the exception sequencer and the memory-address mux:
// address-source select codes, cause codes, FSM state encoding and the
// mapping from a latched cause to the address source of its handler vector.
package exc_seq_pkg;

    // Memory-address source select codes
    localparam logic [2:0] SRC_PC     = 3'b000;
    localparam logic [2:0] SRC_ALUOUT = 3'b001;
    localparam logic [2:0] SRC_NOOP   = 3'b010;
    localparam logic [2:0] SRC_OVFL   = 3'b011;
    localparam logic [2:0] SRC_DIV0   = 3'b100;

    // Width of the wait down-counter; holds MEM_WAIT-1 for MEM_WAIT up to 7
    localparam int unsigned WAIT_CNT_W = 3;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_NOOP = 2'b01,
        CAUSE_OVFL = 2'b10,
        CAUSE_DIV0 = 2'b11
    } cause_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Address source that fetches the handler vector for a given cause
    function automatic logic [2:0] cause_src(input cause_e c);
        case (c)
            CAUSE_NOOP: return SRC_NOOP;
            CAUSE_OVFL: return SRC_OVFL;
            CAUSE_DIV0: return SRC_DIV0;
            default:    return SRC_PC;
        endcase
    endfunction

endpackage

// File: rtl/exc_wait_cnt.sv
// Down-counter that times the memory wait. Loaded on entry to WAIT, it
// counts down to zero and then holds; zero_o marks the last wait cycle.
module exc_wait_cnt
    import exc_seq_pkg::*;
#(
    parameter int unsigned W = WAIT_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] cnt_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load has priority, otherwise decrement until zero
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = cnt_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignment so all flops update together at the edge
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/exc_seq.sv
// Exception entry sequencer. Accepts one exception at a time from IDLE,
// records the faulting PC and cause, steers the memory-address mux to the
// handler vector, waits MEM_WAIT cycles for the read, loads the handler
// address and strobes a PC write. Requests that arrive while busy are
// dropped and recorded in a sticky lost_exc flag.
module exc_seq
    import exc_seq_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ctrl_src_mem,
    input  logic        exc_noop,
    input  logic        exc_ovfl,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [2:0]  src_add_mem,
    output logic [31:0] epc_out,
    output logic [1:0]  cause,
    output logic [31:0] pc_out,
    output logic        pc_wr,
    output logic        busy,
    output logic        done,
    output logic        lost_exc
);

    // Counter load value: WAIT exits on the cycle the counter reads zero
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(MEM_WAIT - 1);

    state_e      state_q, state_d;
    cause_e      cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        lost_q, lost_d;
    logic        cnt_load;
    logic        cnt_zero;
    logic        any_req;

    // Only the low byte of the memory word carries the handler address
    logic        unused_mem_hi;
    assign unused_mem_hi = ^mem_data_in[31:8];

    assign any_req = exc_noop | exc_ovfl | exc_div0;

    exc_wait_cnt #(
        .W (WAIT_CNT_W)
    ) u_wait_cnt (
        .clk       (clk),
        .reset     (reset),
        .load_i    (cnt_load),
        .cnt_val_i (WAIT_LOAD),
        .zero_o    (cnt_zero)
    );

    // Next-state logic and register updates for the entry sequence
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        pc_out_d = pc_out_q;
        lost_d   = lost_q;
        cnt_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_SELECT;
                    // Highest-priority request wins; the others are discarded
                    if (exc_div0) begin
                        cause_d = CAUSE_DIV0;
                    end else if (exc_ovfl) begin
                        cause_d = CAUSE_OVFL;
                    end else begin
                        cause_d = CAUSE_NOOP;
                    end
                end
            end
            ST_SELECT: begin
                // pc_in is already PC+4; wraps modulo 2^32 at zero
                epc_d    = pc_in - 32'd4;
                cnt_load = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pc_out_d = {24'b0, mem_data_in[7:0]};
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any request outside IDLE is dropped and remembered until reset
        if ((state_q != ST_IDLE) && any_req) begin
            lost_d = 1'b1;
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cause_q  <= CAUSE_NONE;
            epc_q    <= '0;
            pc_out_q <= '0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            pc_out_q <= pc_out_d;
            lost_q   <= lost_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign pc_wr       = (state_q == ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign src_add_mem = (state_q == ST_IDLE) ? ctrl_src_mem : cause_src(cause_q);
    assign epc_out     = epc_q;
    assign cause       = cause_q;
    assign pc_out      = pc_out_q;
    assign lost_exc    = lost_q;

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: three builds (MEM_WAIT = 2, 1, 7) share one stimulus.
// Each accepted exception pushes its expected epc/cause/handler address to a
// queue; a monitor pops and compares when the MEM_WAIT=2 build strobes pc_wr.
// Latency is counted in rising edges from the edge after which the request
// is driven; the request itself is sampled on the first of those edges.
module tb_exc_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  ctrl_src_mem;
    logic        exc_noop, exc_ovfl, exc_div0;
    logic [31:0] pc_in, mem_data_in;

    logic [2:0]  src_add_mem,  w1_src,   w7_src;
    logic [31:0] epc_out,      w1_epc,   w7_epc;
    logic [1:0]  cause,        w1_cause, w7_cause;
    logic [31:0] pc_out,       w1_pco,   w7_pco;
    logic        pc_wr,        w1_pcwr,  w7_pcwr;
    logic        busy,         w1_busy,  w7_busy;
    logic        done,         w1_done,  w7_done;
    logic        lost_exc,     w1_lost,  w7_lost;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  cause;
        logic [31:0] epc;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    logic exp_lost;

    always #5 clk = ~clk;

    exc_seq #(.MEM_WAIT(2)) dut (
        .clk(clk), .reset(reset), .ctrl_src_mem(ctrl_src_mem),
        .exc_noop(exc_noop), .exc_ovfl(exc_ovfl), .exc_div0(exc_div0),
        .pc_in(pc_in), .mem_data_in(mem_data_in),
        .src_add_mem(src_add_mem), .epc_out(epc_out), .cause(cause),
        .pc_out(pc_out), .pc_wr(pc_wr), .busy(busy), .done(done),
        .lost_exc(lost_exc)
    );

    exc_seq #(.MEM_WAIT(1)) dut_w1 (
        .clk(clk), .reset(reset), .ctrl_src_mem(ctrl_src_mem),
        .exc_noop(exc_noop), .exc_ovfl(exc_ovfl), .exc_div0(exc_div0),
        .pc_in(pc_in), .mem_data_in(mem_data_in),
        .src_add_mem(w1_src), .epc_out(w1_epc), .cause(w1_cause),
        .pc_out(w1_pco), .pc_wr(w1_pcwr), .busy(w1_busy), .done(w1_done),
        .lost_exc(w1_lost)
    );

    exc_seq #(.MEM_WAIT(7)) dut_w7 (
        .clk(clk), .reset(reset), .ctrl_src_mem(ctrl_src_mem),
        .exc_noop(exc_noop), .exc_ovfl(exc_ovfl), .exc_div0(exc_div0),
        .pc_in(pc_in), .mem_data_in(mem_data_in),
        .src_add_mem(w7_src), .epc_out(w7_epc), .cause(w7_cause),
        .pc_out(w7_pco), .pc_wr(w7_pcwr), .busy(w7_busy), .done(w7_done),
        .lost_exc(w7_lost)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: each PC write must match the oldest pending entry
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && pc_wr === 1'b1) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_pc_out", pc_out, e.pc);
                check("sb_cause", 32'(cause), 32'(e.cause));
                check("sb_epc", epc_out, e.epc);
                check("sb_done", 32'(done), 32'd1);
            end
        end
    end

    // Launch one request from IDLE (called at posedge+1), optionally pulse
    // exc_div0 after edge pulse_at, and watch 14 edges.
    task automatic run_seq(input logic [2:0] req, input logic [31:0] pc,
                           input logic [31:0] mem, input logic [1:0] exp_cause,
                           input logic [2:0] exp_src, input int pulse_at,
                           input bit timing);
        int   n_wr = 0, n_busy = 0, lat = 0;
        int   w1_wr = 0, w1_nb = 0, w1_lat = 0;
        int   w7_wr = 0, w7_nb = 0, w7_lat = 0;
        exp_t e;
        {exc_div0, exc_ovfl, exc_noop} = req;
        pc_in       = pc;
        mem_data_in = mem;
        e.cause = exp_cause;
        e.epc   = pc - 32'd4;
        e.pc    = {24'h0, mem[7:0]};
        sb.push_back(e);
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) {exc_div0, exc_ovfl, exc_noop} = 3'b000;
            if (pulse_at > 0 && n == pulse_at) begin
                exc_div0 = 1'b1;
                exp_lost = 1'b1;
            end
            if (pulse_at > 0 && n == pulse_at + 1) exc_div0 = 1'b0;
            if (busy) begin
                n_busy++;
                check("src_busy", 32'(src_add_mem), 32'(exp_src));
            end
            if (pc_wr) begin n_wr++; if (lat == 0) lat = n; end
            if (w1_busy) w1_nb++;
            if (w1_pcwr) begin w1_wr++; if (w1_lat == 0) w1_lat = n; end
            if (w7_busy) w7_nb++;
            if (w7_pcwr) begin w7_wr++; if (w7_lat == 0) w7_lat = n; end
        end
        check("wr_count", n_wr, 1);
        check("wr_latency", lat, 5);
        check("busy_len", n_busy, 5);
        check("cause_hold", 32'(cause), 32'(exp_cause));
        check("epc_hold", epc_out, pc - 32'd4);
        check("lost_exc", 32'(lost_exc), 32'(exp_lost));
        check("idle_after", 32'(busy), 32'd0);
        if (timing) begin
            check("w1_wr_count", w1_wr, 1);
            check("w1_latency", w1_lat, 4);
            check("w1_busy_len", w1_nb, 4);
            check("w7_wr_count", w7_wr, 1);
            check("w7_latency", w7_lat, 10);
            check("w7_busy_len", w7_nb, 10);
        end
    endtask

    // Compare every reset-state output of the MEM_WAIT=2 build
    task automatic check_reset_state(input string tag);
        check({tag, "_epc"}, epc_out, 32'h0);
        check({tag, "_pc_out"}, pc_out, 32'h0);
        check({tag, "_cause"}, 32'(cause), 32'd0);
        check({tag, "_lost"}, 32'(lost_exc), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pc_wr"}, 32'(pc_wr), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_src"}, 32'(src_add_mem), 32'(ctrl_src_mem));
    endtask

    initial begin
        reset        = 1'b0;
        ctrl_src_mem = 3'b011;
        {exc_div0, exc_ovfl, exc_noop} = 3'b000;
        pc_in        = 32'h0;
        mem_data_in  = 32'h0;
        exp_lost     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_pc_wr", 32'(pc_wr), 32'd0);

        // IDLE pass-through sweep
        for (int v = 0; v <= 4; v++) begin
            @(posedge clk);
            #1;
            ctrl_src_mem = 3'(v);
            #2;
            check("pass_src", 32'(src_add_mem), 32'(v));
        end
        @(posedge clk);
        #1;

        // Overflow, with latency checks on all three builds
        run_seq(3'b010, 32'h0000_0104, 32'h0000_0040, 2'b10, 3'b011, 0, 1'b1);
        // Simultaneous requests: div0 wins, nothing lost
        run_seq(3'b111, 32'h0000_2000, 32'h1234_5678, 2'b11, 3'b100, 0, 1'b0);
        // EPC wrap and byte masking of the handler address
        run_seq(3'b001, 32'h0000_0000, 32'hDEAD_BEA5, 2'b01, 3'b010, 0, 1'b0);
        check("epc_wrap", epc_out, 32'hFFFF_FFFC);
        // Request during WAIT is lost
        run_seq(3'b001, 32'h0000_0300, 32'h0000_0011, 2'b01, 3'b010, 2, 1'b0);

        // Reset asserted in LOAD
        exc_noop    = 1'b1;
        pc_in       = 32'h0000_0500;
        mem_data_in = 32'h0000_0022;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) exc_noop = 1'b0;
        end
        #1 reset = 1'b0;
        #1;
        exp_lost = 1'b0;
        check_reset_state("mid_rst");
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold_pc_wr", 32'(pc_wr), 32'd0);
        end
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);

        // Normal noop after reset; a request sampled during DONE is lost
        run_seq(3'b001, 32'h0000_0600, 32'h0000_007F, 2'b01, 3'b010, 5, 1'b0);

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
